// File: rtl/typedefs.sv
// Shared types for the 8-bit accumulator CPU.
//   opcode_t : 3-bit instruction opcode held in the instruction register
//   state_t  : 3-bit sequencer phase, stepped in numeric order 0..7
//   is_aluop : opcodes whose result is loaded into the accumulator from the alu
package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Wrapping 3-bit phase counter for the CPU sequencer.
//   clk   : system clock
//   rst   : synchronous active-high reset to INST_ADDR
//   hold  : when 1 the phase keeps its value this cycle
//   phase : current phase
module phase_counter
  import typedefs::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  output state_t phase
);

  state_t phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (!hold) phase_d = state_t'(3'(phase_q) + 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= INST_ADDR;
    else     phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Eight-phase control sequencer for the 8-bit accumulator CPU.
//   clk, rst   : system clock, synchronous active-high reset
//   opcode     : current instruction opcode
//   zero       : accumulator-zero flag, used by SKZ in ALU_OP
//   go         : resume pulse for halt or step pause
//   step_mode  : pause before each instruction fetch
//   phase      : current phase
//   mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr : datapath strobes
//   retired    : one-cycle pulse in the STORE phase of each instruction
module cpu_sequencer
  import typedefs::*;
(
  input  logic    clk,
  input  logic    rst,
  input  opcode_t opcode,
  input  logic    zero,
  input  logic    go,
  input  logic    step_mode,
  output state_t  phase,
  output logic    mem_rd,
  output logic    load_ir,
  output logic    halt,
  output logic    inc_pc,
  output logic    load_ac,
  output logic    load_pc,
  output logic    mem_wr,
  output logic    retired
);

  logic halted_q, halted_d;
  logic paused_q, paused_d;
  logic hold;
  logic aluop;
  logic op_addr_entry;

  phase_counter u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .hold  (hold),
    .phase (phase)
  );

  always_comb begin
    halted_d = halted_q;
    paused_d = paused_q;
    hold     = 1'b0;
    if (halted_q || paused_q) begin
      // Only one of the flags can be set; go releases it and lets the phase move on.
      hold = !go;
      if (go) begin
        halted_d = 1'b0;
        paused_d = 1'b0;
      end
    end else if (phase == OP_ADDR && opcode == HLT) begin
      halted_d = 1'b1;
      hold     = 1'b1;
    end else if (phase == STORE) begin
      paused_d = step_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
      paused_q <= paused_d;
    end
  end

  // halted sets at the end of the first OP_ADDR cycle and go always moves the
  // phase on to OP_FETCH, so !halted_q marks exactly the OP_ADDR entry cycle.
  assign op_addr_entry = (phase == OP_ADDR) && !halted_q;
  assign aluop         = is_aluop(opcode);

  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    retired = 1'b0;
    unique case (phase)
      INST_ADDR: ;
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = op_addr_entry;
        halt   = (opcode == HLT) || halted_q;
      end
      OP_FETCH: mem_rd = aluop;
      ALU_OP: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (opcode == SKZ) && zero;
        load_pc = (opcode == JMP);
      end
      STORE: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (opcode == JMP);
        load_pc = (opcode == JMP);
        mem_wr  = (opcode == STO);
        retired = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
  import typedefs::*;

  logic    clk = 1'b0;
  logic    rst;
  opcode_t opcode;
  logic    zero;
  logic    go;
  logic    step_mode;
  state_t  phase;
  logic    mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, retired;

  int checks = 0;
  int errors = 0;

  cpu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .zero      (zero),
    .go        (go),
    .step_mode (step_mode),
    .phase     (phase),
    .mem_rd    (mem_rd),
    .load_ir   (load_ir),
    .halt      (halt),
    .inc_pc    (inc_pc),
    .load_ac   (load_ac),
    .load_pc   (load_pc),
    .mem_wr    (mem_wr),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ph     = 0;
  bit m_halted = 0;
  bit m_paused = 0;
  bit started  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph     <= 0;
      m_halted <= 0;
      m_paused <= 0;
      started  <= 1;
    end else if (m_halted) begin
      if (go) begin m_halted <= 0; m_ph <= 5; end
    end else if (m_paused) begin
      if (go) begin m_paused <= 0; m_ph <= 1; end
    end else if (m_ph == 4 && opcode == HLT) begin
      m_halted <= 1;
    end else begin
      m_ph <= (m_ph + 1) % 8;
      if (m_ph == 7) m_paused <= step_mode;
    end
  end

  // {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, retired}
  function automatic logic [7:0] exp_strobes(input int ph, input opcode_t op,
                                             input logic z, input bit hltd);
    bit a;
    a = (op == ADD || op == AND || op == XOR || op == LDA);
    case (ph)
      1:       return 8'b1000_0000;
      2, 3:    return 8'b1100_0000;
      4:       return {2'b00, (hltd || op == HLT), !hltd, 4'b0000};
      5:       return {a, 7'b0};
      6:       return {a, 2'b00, (op == SKZ && z), a, (op == JMP), 2'b00};
      7:       return {a, 2'b00, (op == JMP), a, (op == JMP), (op == STO), 1'b1};
      default: return 8'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("model_phase", 32'(phase), 32'(m_ph));
      chk("model_strobes",
          {24'b0, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, retired},
          {24'b0, exp_strobes(m_ph, opcode, zero, m_halted)});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting at phase 0, recording strobes per phase.
  task automatic run8(output logic [7:0] incv, output logic [7:0] lpcv,
                      output logic [7:0] mwrv, output logic [7:0] ldacv,
                      output logic [7:0] mrdv, output logic [7:0] retv);
    for (int i = 0; i < 8; i++) begin
      chk("phase_seq", 32'(phase), 32'(i));
      incv[i]  = inc_pc;
      lpcv[i]  = load_pc;
      mwrv[i]  = mem_wr;
      ldacv[i] = load_ac;
      mrdv[i]  = mem_rd;
      retv[i]  = retired;
      tick();
    end
  endtask

  logic [7:0] incv, lpcv, mwrv, ldacv, mrdv, retv;
  int inc_cnt;

  initial begin
    rst = 1; go = 0; zero = 0; step_mode = 0; opcode = ADD;
    tick();
    chk("reset_phase", 32'(phase), 32'd0);
    chk("reset_strobes", {24'b0, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, retired}, 32'd0);
    rst = 0;

    // ADD: two full instructions
    for (int n = 0; n < 2; n++) begin
      run8(incv, lpcv, mwrv, ldacv, mrdv, retv);
      chk("add_store", {28'b0, mrdv[7], ldacv[7], retv[7], mwrv[7]}, 32'b1110);
      chk("add_retired", 32'(retv), 32'h80);
    end

    // SKZ with zero=1 then zero=0
    opcode = SKZ; zero = 1;
    run8(incv, lpcv, mwrv, ldacv, mrdv, retv);
    chk("skz_z1_inc", 32'(incv), 32'b0101_0000);
    zero = 0;
    run8(incv, lpcv, mwrv, ldacv, mrdv, retv);
    chk("skz_z0_inc", 32'(incv), 32'b0001_0000);

    // JMP and STO
    opcode = JMP;
    run8(incv, lpcv, mwrv, ldacv, mrdv, retv);
    chk("jmp_load_pc", 32'(lpcv), 32'b1100_0000);
    chk("jmp_inc_pc", 32'(incv), 32'b1001_0000);
    opcode = STO;
    run8(incv, lpcv, mwrv, ldacv, mrdv, retv);
    chk("sto_mem_wr", 32'(mwrv), 32'b1000_0000);

    // HLT: hold for 10 cycles with a single inc_pc pulse
    opcode = HLT;
    repeat (4) tick();
    chk("hlt_entry_phase", 32'(phase), 32'd4);
    inc_cnt = int'(inc_pc);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hlt_hold_phase", 32'(phase), 32'd4);
      chk("hlt_halt", 32'(halt), 32'd1);
      inc_cnt += int'(inc_pc);
    end
    chk("hlt_inc_once", 32'(inc_cnt), 32'd1);
    go = 1;
    tick();
    chk("resume_phase", 32'(phase), 32'd5);
    chk("resume_halt", 32'(halt), 32'd0);
    tick();                       // go still high, not halted: plain advance
    go = 0;
    chk("go_held_phase", 32'(phase), 32'd6);
    repeat (2) tick();
    chk("after_hlt_phase", 32'(phase), 32'd0);

    // Step mode pause
    opcode = ADD; step_mode = 1;
    run8(incv, lpcv, mwrv, ldacv, mrdv, retv);
    for (int i = 0; i < 5; i++) begin
      chk("pause_phase", 32'(phase), 32'd0);
      chk("pause_strobes", {24'b0, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, retired}, 32'd0);
      tick();
    end
    go = 1;
    tick();
    go = 0; step_mode = 0;
    chk("step_release", 32'(phase), 32'd1);
    repeat (7) tick();
    chk("no_pause_phase", 32'(phase), 32'd0);
    go = 1;
    tick();
    go = 0;
    chk("go_ignored", 32'(phase), 32'd1);

    // Reset in ALU_OP together with go
    opcode = STO;
    repeat (5) tick();
    chk("at_alu_op", 32'(phase), 32'd6);
    rst = 1; go = 1;
    tick();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_strobes", {24'b0, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, retired}, 32'd0);
    rst = 0; go = 0;
    tick();
    chk("rst_no_retire", 32'(retired), 32'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
